// File: rtl/count_mod_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Package : count_defs                                                    |
// | Shared constants and helpers for the clock/calendar counter chain.      |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
package count_defs;

   // Number of states per calendar unit
   localparam int SEC_MOD   = 60;
   localparam int MIN_MOD   = 60;
   localparam int HOUR_MOD  = 24;
   localparam int MONTH_MOD = 12;

   // Lowest value per unit (seconds/minutes/hours start at 0)
   localparam int DAY_MIN   = 1;
   localparam int MONTH_MIN = 1;

   // Default counter width per unit
   localparam int SEC_W   = 6;
   localparam int MIN_W   = 6;
   localparam int HOUR_W  = 5;
   localparam int DAY_W   = 5;
   localparam int MONTH_W = 4;

   // Days-in-month constants feeding the day counter's top_in
   localparam logic [4:0] DAYS_LONG     = 5'd31;
   localparam logic [4:0] DAYS_SHORT    = 5'd30;
   localparam logic [4:0] DAYS_FEB      = 5'd28;
   localparam logic [4:0] DAYS_FEB_LEAP = 5'd29;

   // Last day of a month (1..12); out-of-range months fall back to 31
   function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
      logic [4:0] d;
      case (month)
         4'd2:                     d = leap ? DAYS_FEB_LEAP : DAYS_FEB;
         4'd4, 4'd6, 4'd9, 4'd11:  d = DAYS_SHORT;
         default:                  d = DAYS_LONG;
      endcase
      return d;
   endfunction

   // Two-digit BCD of a constant, used for reset values of the digit registers
   function automatic logic [7:0] bcd8(input int unsigned v);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_99.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : bin2bcd_99                                                    |
// | Combinational 7-bit binary to two BCD digits, valid for 0..99.          |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module bin2bcd_99 (
   input  logic [6:0] bin,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic [6:0] rem;

   // Repeated subtraction of ten; nine stages cover the full 0..99 range
   always_comb begin
      tens = 4'd0;
      rem  = bin;
      for (int i = 0; i < 9; i++) begin
         if (rem >= 7'd10) begin
            rem  = rem - 7'd10;
            tens = tens + 4'd1;
         end
      end
      ones = rem[3:0];
   end

endmodule
`default_nettype wire

// File: rtl/count_mod.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module  : count_mod                                                     |
// | Parametrised modulo counter with MIN..top range, runtime top, borrow,   |
// | checked parallel load and a registered BCD split of the count.          |
// | Revision: 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module count_mod
   import count_defs::*;
#(
   parameter int W          = 5,
   parameter int MOD        = 24,
   parameter int MIN        = 0,
   parameter int USE_TOP_IN = 0
) (
   input  logic         clk,
   input  logic         set_c,
   input  logic         pulse_in,
   input  logic         pulse_dn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] top_in,
   output logic         pulse_out,
   output logic         borrow_out,
   output logic         load_err,
   output logic [W-1:0] cnt,
   output logic [3:0]   bcd_tens,
   output logic [3:0]   bcd_ones
);

   localparam int         STATIC_TOP = MIN + MOD - 1;
   localparam logic [7:0] MIN_BCD    = bcd8(MIN);

   // A runtime top may reach 2^W-1, which must still fit in two decimal digits
   generate
      if (W < 2 || W > 7 || MOD < 1 || MIN < 0 || STATIC_TOP > 99 ||
          STATIC_TOP > (2**W) - 1 || (USE_TOP_IN != 0 && (2**W) - 1 > 99)) begin : g_param_check
         $error("count_mod: illegal parameter combination");
      end
   endgenerate

   logic [W-1:0] top_raw;
   logic [W-1:0] top;
   logic [W-1:0] min_w;
   logic [W:0]   cnt_x;
   logic [W:0]   top_x;
   logic [W:0]   min_x;
   logic [W:0]   ld_x;
   logic [W-1:0] next_cnt;
   logic         next_carry;
   logic         next_borrow;
   logic         next_err;
   logic [6:0]   bcd_in;
   logic [3:0]   next_tens;
   logic [3:0]   next_ones;

   assign min_w   = W'(MIN);
   assign top_raw = (USE_TOP_IN != 0) ? top_in : W'(STATIC_TOP);
   // A runtime top below MIN collapses the range to the single value MIN
   assign top     = (top_raw < min_w) ? min_w : top_raw;

   // Comparisons done one bit wider so the range checks never alias
   assign cnt_x = {1'b0, cnt};
   assign top_x = {1'b0, top};
   assign min_x = {1'b0, min_w};
   assign ld_x  = {1'b0, load_val};

   // Next-state decision: load beats counting; opposing enables cancel
   always_comb begin
      next_cnt    = cnt;
      next_carry  = 1'b0;
      next_borrow = 1'b0;
      next_err    = 1'b0;
      if (load) begin
         if (ld_x >= min_x && ld_x <= top_x) begin
            next_cnt = load_val;
         end else begin
            next_cnt = min_w;
            next_err = 1'b1;
         end
      end else if (pulse_in && !pulse_dn) begin
         // cnt may sit above a shrunken top; it wraps on the next increment
         if (cnt_x >= top_x) begin
            next_cnt   = min_w;
            next_carry = 1'b1;
         end else begin
            next_cnt = cnt + 1'b1;
         end
      end else if (pulse_dn && !pulse_in) begin
         if (cnt_x <= min_x) begin
            next_cnt    = top;
            next_borrow = 1'b1;
         end else begin
            next_cnt = cnt - 1'b1;
         end
      end
   end

   // Digits come from the next-state count so they update together with cnt
   assign bcd_in = 7'(next_cnt);

   bin2bcd_99 u_bcd (
      .bin  (bcd_in),
      .tens (next_tens),
      .ones (next_ones)
   );

   // Count, single-cycle pulses and BCD digits registered on the same edge
   always_ff @(posedge clk or negedge set_c) begin
      if (!set_c) begin
         cnt        <= min_w;
         pulse_out  <= 1'b0;
         borrow_out <= 1'b0;
         load_err   <= 1'b0;
         bcd_tens   <= MIN_BCD[7:4];
         bcd_ones   <= MIN_BCD[3:0];
      end else begin
         cnt        <= next_cnt;
         pulse_out  <= next_carry;
         borrow_out <= next_borrow;
         load_err   <= next_err;
         bcd_tens   <= next_tens;
         bcd_ones   <= next_ones;
      end
   end

endmodule
`default_nettype wire
